ddr_write_arbiter: RTL and testbench

Round-robin arbiter that shares one DDR write channel (request / data / response) between `NUM_PORTS` requesters. It sits between the requester engines and the single DDR write datapath that converts requests into S2MM command and stream traffic. Exactly one transaction is in flight at a time: grant, forward the request, forward the data burst up to `last`, then route the response back to the granted port.

---
 rtl/ddr_write_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ddr_write_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_write_arbiter.sv
`default_nettype none
// ============================================================================
// ddr_write_arbiter: round-robin sharing of one DDR write channel
// (request / data burst / response) between NUM_PORTS requesters.
// Revision: 1.0
// ============================================================================
module ddr_write_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int GNT_WIDTH  = 3
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_PORTS-1:0]             s_wreq_valid,
  output logic [NUM_PORTS-1:0]             s_wreq_ready,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_wreq_addr,
  input  logic [NUM_PORTS*SIZE_WIDTH-1:0]  s_wreq_size,
  input  logic [NUM_PORTS-1:0]             s_wdata_valid,
  output logic [NUM_PORTS-1:0]             s_wdata_ready,
  input  logic [NUM_PORTS-1:0]             s_wdata_last,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_wdata,
  output logic [NUM_PORTS-1:0]             s_wresp_valid,
  output logic [NUM_PORTS*2-1:0]           s_wresp,
  output logic                             m_wreq_valid,
  input  logic                             m_wreq_ready,
  output logic [ADDR_WIDTH-1:0]            m_wreq_addr,
  output logic [SIZE_WIDTH-1:0]            m_wreq_size,
  output logic                             m_wdata_valid,
  input  logic                             m_wdata_ready,
  output logic                             m_wdata_last,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  input  logic                             m_wresp_valid,
  input  logic [1:0]                       m_wresp,
  output logic [GNT_WIDTH-1:0]             gnt_idx,
  output logic                             busy,
  output logic                             unexp_resp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                 state;
  logic [GNT_WIDTH-1:0]   rr_ptr;
  logic [GNT_WIDTH-1:0]   pick;
  logic                   pick_found;
  logic [GNT_WIDTH-1:0]   gnt_inc;

  logic                   sel_req_valid;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [SIZE_WIDTH-1:0]  sel_size;
  logic                   sel_data_valid;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   sel_last;

  // Search offsets 0..N-1 from rr_ptr; the first valid port found wins.
  always_comb begin
    logic [GNT_WIDTH:0] cand;
    cand       = '0;
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, rr_ptr} + (GNT_WIDTH+1)'(k);
      if (cand >= (GNT_WIDTH+1)'(NUM_PORTS)) begin
        cand = cand - (GNT_WIDTH+1)'(NUM_PORTS);
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!pick_found && s_wreq_valid[i] && (cand == (GNT_WIDTH+1)'(i))) begin
          pick_found = 1'b1;
          pick       = GNT_WIDTH'(i);
        end
      end
    end
  end

  assign gnt_inc = (gnt_idx == GNT_WIDTH'(NUM_PORTS - 1)) ? '0 : gnt_idx + GNT_WIDTH'(1);

  always_comb begin
    sel_req_valid  = 1'b0;
    sel_addr       = '0;
    sel_size       = '0;
    sel_data_valid = 1'b0;
    sel_data       = '0;
    sel_last       = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_idx == GNT_WIDTH'(i)) begin
        sel_req_valid  = s_wreq_valid[i];
        sel_addr       = s_wreq_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_size       = s_wreq_size[i*SIZE_WIDTH +: SIZE_WIDTH];
        sel_data_valid = s_wdata_valid[i];
        sel_data       = s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last       = s_wdata_last[i];
      end
    end
  end

  assign m_wreq_valid  = (state == REQ) && sel_req_valid;
  assign m_wreq_addr   = sel_addr;
  assign m_wreq_size   = sel_size;
  assign m_wdata_valid = (state == DATA) && sel_data_valid;
  assign m_wdata       = sel_data;
  assign m_wdata_last  = sel_last;

  // Only the granted slice sees readies/response strobe; response code fans out.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic hit;
    assign hit               = (gnt_idx == GNT_WIDTH'(g));
    assign s_wreq_ready[g]   = hit && (state == REQ)  && m_wreq_ready;
    assign s_wdata_ready[g]  = hit && (state == DATA) && m_wdata_ready;
    assign s_wresp_valid[g]  = hit && (state == RESP) && m_wresp_valid;
    assign s_wresp[2*g +: 2] = m_wresp;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      gnt_idx    <= '0;
      rr_ptr     <= '0;
      busy       <= 1'b0;
      unexp_resp <= 1'b0;
    end else begin
      // A response outside RESP is dropped and remembered until reset.
      if (m_wresp_valid && (state != RESP)) begin
        unexp_resp <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt_idx <= pick;
            busy    <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (m_wreq_valid && m_wreq_ready) begin
            rr_ptr <= gnt_inc;
            state  <= DATA;
          end
        end
        DATA: begin
          if (m_wdata_valid && m_wdata_ready && m_wdata_last) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (m_wresp_valid) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ddr_write_arbiter: scoreboard bench with per-port requester drivers,
// a downstream responder model and a decoupled output monitor.
// Revision: 1.0
// ============================================================================
module tb_ddr_write_arbiter;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int SW = 16;
  localparam int DW = 64;
  localparam int GW = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [NP-1:0]    s_wreq_valid, s_wreq_ready, s_wdata_valid, s_wdata_ready;
  logic [NP-1:0]    s_wdata_last, s_wresp_valid;
  logic [NP*AW-1:0] s_wreq_addr;
  logic [NP*SW-1:0] s_wreq_size;
  logic [NP*DW-1:0] s_wdata;
  logic [NP*2-1:0]  s_wresp;
  logic m_wreq_valid, m_wreq_ready, m_wdata_valid, m_wdata_ready, m_wdata_last;
  logic [AW-1:0] m_wreq_addr;
  logic [SW-1:0] m_wreq_size;
  logic [DW-1:0] m_wdata;
  logic m_wresp_valid;
  logic [1:0] m_wresp;
  logic [GW-1:0] gnt_idx;
  logic busy, unexp_resp;

  ddr_write_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
                      .DATA_WIDTH(DW), .GNT_WIDTH(GW)) dut (
    .clk(clk), .rstn(rstn),
    .s_wreq_valid(s_wreq_valid), .s_wreq_ready(s_wreq_ready),
    .s_wreq_addr(s_wreq_addr), .s_wreq_size(s_wreq_size),
    .s_wdata_valid(s_wdata_valid), .s_wdata_ready(s_wdata_ready),
    .s_wdata_last(s_wdata_last), .s_wdata(s_wdata),
    .s_wresp_valid(s_wresp_valid), .s_wresp(s_wresp),
    .m_wreq_valid(m_wreq_valid), .m_wreq_ready(m_wreq_ready),
    .m_wreq_addr(m_wreq_addr), .m_wreq_size(m_wreq_size),
    .m_wdata_valid(m_wdata_valid), .m_wdata_ready(m_wdata_ready),
    .m_wdata_last(m_wdata_last), .m_wdata(m_wdata),
    .m_wresp_valid(m_wresp_valid), .m_wresp(m_wresp),
    .gnt_idx(gnt_idx), .busy(busy), .unexp_resp(unexp_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input string what);
    tests++;
    fails++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  typedef struct { logic [AW-1:0] addr; logic [SW-1:0] size; int beats; logic [DW-1:0] d0; } job_t;
  typedef struct { logic [AW-1:0] addr; logic [SW-1:0] size; int port; } req_exp_t;
  typedef struct { logic [DW-1:0] data; logic last; } beat_exp_t;
  typedef struct { int port; logic [1:0] code; } resp_exp_t;

  job_t      job_q[NP][$];
  req_exp_t  exp_req_q[$];
  beat_exp_t exp_beat_q[$];
  resp_exp_t exp_resp_q[$];
  logic [1:0] ds_code_q[$];

  logic          req_v[NP];
  logic [AW-1:0] addr_v[NP];
  logic [SW-1:0] size_v[NP];
  logic          dat_v[NP];
  logic [DW-1:0] data_v[NP];
  logic          last_v[NP];
  bit            active[NP];
  int            req_start_cyc[NP];

  int mreq_rise_cyc = 0;
  int resp_cyc = 0;
  int stall_until = 0;
  int unexp_req = 0;
  bit toggle_en = 1'b0;

  // Requester drivers: hold valid until accepted, abort on reset.
  for (genvar g = 0; g < NP; g++) begin : g_drv
    assign s_wreq_valid[g]          = req_v[g];
    assign s_wreq_addr[g*AW +: AW]  = addr_v[g];
    assign s_wreq_size[g*SW +: SW]  = size_v[g];
    assign s_wdata_valid[g]         = dat_v[g];
    assign s_wdata[g*DW +: DW]      = data_v[g];
    assign s_wdata_last[g]          = last_v[g];

    initial begin : drv
      job_t j;
      bit ab;
      req_v[g] = 0; addr_v[g] = '0; size_v[g] = '0;
      dat_v[g] = 0; data_v[g] = '0; last_v[g] = 0;
      active[g] = 0; req_start_cyc[g] = 0;
      forever begin
        @(posedge clk); #1;
        if (job_q[g].size() == 0) continue;
        j = job_q[g].pop_front();
        active[g] = 1; ab = 0;
        req_v[g] = 1; addr_v[g] = j.addr; size_v[g] = j.size;
        req_start_cyc[g] = cyc;
        forever begin
          @(negedge clk);
          if (!rstn) begin ab = 1; break; end
          if (s_wreq_ready[g]) break;
        end
        if (!ab) begin @(posedge clk); #1; end
        req_v[g] = 0;
        for (int b = 0; b < j.beats && !ab; b++) begin
          dat_v[g] = 1; data_v[g] = j.d0 + DW'(b); last_v[g] = (b == j.beats - 1);
          forever begin
            @(negedge clk);
            if (!rstn) begin ab = 1; break; end
            if (s_wdata_ready[g]) break;
          end
          if (!ab) begin @(posedge clk); #1; end
        end
        dat_v[g] = 0; last_v[g] = 0;
        active[g] = 0;
      end
    end
  end

  // Downstream model: readies, one response one cycle after the last beat.
  initial begin : responder
    bit pend;
    int unexp_done;
    pend = 0; unexp_done = 0;
    m_wreq_ready = 0; m_wdata_ready = 0; m_wresp_valid = 0; m_wresp = 2'd0;
    forever begin
      @(negedge clk);
      if (!rstn) pend = 0;
      else if (m_wdata_valid && m_wdata_ready && m_wdata_last) pend = 1;
      @(posedge clk); #1;
      m_wresp_valid = 0;
      m_wreq_ready  = (cyc >= stall_until);
      m_wdata_ready = toggle_en ? !m_wdata_ready : 1'b1;
      if (pend && rstn) begin
        m_wresp_valid = 1;
        m_wresp = (ds_code_q.size() != 0) ? ds_code_q.pop_front() : 2'd0;
        pend = 0;
      end else if (unexp_done != unexp_req) begin
        m_wresp_valid = 1;
        m_wresp = 2'd2;
        unexp_done++;
      end
    end
  end

  // Monitor: pops expected traffic whenever the DUT presents it.
  initial begin : monitor
    logic prev_mv;
    req_exp_t  er;
    beat_exp_t eb;
    resp_exp_t ep;
    int p;
    prev_mv = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin prev_mv = 0; continue; end
      if (m_wreq_valid && !prev_mv) mreq_rise_cyc = cyc;
      prev_mv = m_wreq_valid;
      if (m_wreq_valid && m_wreq_ready) begin
        if (exp_req_q.size() == 0) flag("req_handshake", "got request handshake, required none");
        else begin
          er = exp_req_q.pop_front();
          check("req_addr", m_wreq_addr, er.addr);
          check("req_size", m_wreq_size, er.size);
          check("gnt_idx", gnt_idx, er.port);
        end
      end
      if (m_wdata_valid && m_wdata_ready) begin
        if (exp_beat_q.size() == 0) flag("data_beat", "got extra data beat, required none");
        else begin
          eb = exp_beat_q.pop_front();
          check("beat_data", m_wdata, eb.data);
          check("beat_last", m_wdata_last, eb.last);
        end
      end
      if (s_wresp_valid != '0) begin
        resp_cyc = cyc;
        check("resp_onehot", $countones(s_wresp_valid), 1);
        p = 0;
        for (int i = 0; i < NP; i++) if (s_wresp_valid[i]) p = i;
        if (exp_resp_q.size() == 0) flag("resp_strobe", "got s_wresp_valid pulse, required none");
        else begin
          ep = exp_resp_q.pop_front();
          check("resp_port", p, ep.port);
          check("resp_code", s_wresp[2*p +: 2], ep.code);
        end
      end
      if (s_wdata_ready != '0) begin
        for (int i = 0; i < NP; i++)
          check("wdata_ready_ungranted", s_wdata_ready[i] & ~dat_v[i], 1'b0);
      end
    end
  end

  task automatic issue(input int p, input logic [AW-1:0] a, input logic [SW-1:0] s,
                       input int beats, input int exp_beats, input logic [DW-1:0] d0,
                       input bit has_resp, input logic [1:0] code);
    job_t jb;
    req_exp_t er;
    beat_exp_t eb;
    resp_exp_t ep;
    jb.addr = a; jb.size = s; jb.beats = beats; jb.d0 = d0;
    job_q[p].push_back(jb);
    er.addr = a; er.size = s; er.port = p;
    exp_req_q.push_back(er);
    for (int b = 0; b < exp_beats; b++) begin
      eb.data = d0 + DW'(b); eb.last = (b == beats - 1);
      exp_beat_q.push_back(eb);
    end
    if (has_resp) begin
      ds_code_q.push_back(code);
      ep.port = p; ep.code = code;
      exp_resp_q.push_back(ep);
    end
  endtask

  task automatic wait_done(input string name, input int bound);
    bit done;
    done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      @(posedge clk);
      done = (exp_req_q.size() == 0) && (exp_beat_q.size() == 0) && (exp_resp_q.size() == 0);
      for (int k = 0; k < NP; k++) if (job_q[k].size() != 0 || active[k]) done = 0;
    end
    if (!done) flag(name, "got transaction still pending, required completion within bound");
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_m_wreq_valid"}, m_wreq_valid, 1'b0);
    check({tag, "_m_wdata_valid"}, m_wdata_valid, 1'b0);
    check({tag, "_s_wreq_ready"}, s_wreq_ready, '0);
    check({tag, "_s_wdata_ready"}, s_wdata_ready, '0);
    check({tag, "_s_wresp_valid"}, s_wresp_valid, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_gnt_idx"}, gnt_idx, '0);
    check({tag, "_unexp_resp"}, unexp_resp, 1'b0);
  endtask

  initial begin : main
    bit reached;
    repeat (3) @(posedge clk);
    #2 check_quiet("reset");
    @(negedge clk) rstn = 1'b1;

    // Single port, 4 beats: arbitration latency 1, 7 cycles IDLE to IDLE.
    issue(0, 32'h1000, 16'd32, 4, 4, 64'hA0, 1, 2'd0);
    wait_done("t1_done", 100);
    check("t1_arb_latency", mreq_rise_cyc - req_start_cyc[0], 1);
    check("t1_txn_cycles", resp_cyc - req_start_cyc[0], 6);
    check("t1_busy_after", busy, 1'b0);

    // Contention: rr_ptr is 1 after port 0, so grants go 1,0,1,0.
    issue(1, 32'h2000, 16'd16, 2, 2, 64'hB0, 1, 2'd0);
    issue(0, 32'h3000, 16'd16, 2, 2, 64'hC0, 1, 2'd1);
    issue(1, 32'h2100, 16'd16, 2, 2, 64'hB8, 1, 2'd2);
    issue(0, 32'h3100, 16'd16, 2, 2, 64'hC8, 1, 2'd0);
    wait_done("t2_done", 200);

    // Backpressure: request stall then toggling data ready, port 0 waiting.
    stall_until = cyc + 6;
    toggle_en = 1'b1;
    issue(1, 32'h4000, 16'd24, 3, 3, 64'hD0, 1, 2'd1);
    issue(0, 32'h5000, 16'd0, 1, 1, 64'hE0, 1, 2'd0);
    wait_done("t3_done", 200);
    toggle_en = 1'b0;

    // Error response then a normal grant.
    issue(1, 32'h6000, 16'd8, 1, 1, 64'hF0, 1, 2'd3);
    wait_done("t4a_done", 100);
    check("t4_busy_after_err", busy, 1'b0);
    issue(0, 32'h7000, 16'd8, 1, 1, 64'hF8, 1, 2'd0);
    wait_done("t4b_done", 100);

    // Unexpected response in IDLE.
    check("t5_unexp_before", unexp_resp, 1'b0);
    unexp_req++;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t5_unexp_set", unexp_resp, 1'b1);
    check("t5_busy_idle", busy, 1'b0);
    issue(1, 32'h8000, 16'd4, 1, 1, 64'h11, 1, 2'd2);
    wait_done("t5_done", 100);
    check("t5_unexp_sticky", unexp_resp, 1'b1);

    // Reset in DATA after 2 of 4 beats on port 1.
    issue(1, 32'h9000, 16'd32, 4, 2, 64'h20, 0, 2'd0);
    reached = 0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(posedge clk);
      reached = (exp_req_q.size() == 0) && (exp_beat_q.size() == 0);
    end
    if (!reached) flag("t6_reach_beat2", "got fewer than 2 beats, required 2 before reset");
    #2;
    check("t6_gnt_before_reset", gnt_idx, 3'd1);
    check("t6_busy_before_reset", busy, 1'b1);
    rstn = 1'b0;
    #1 check_quiet("t6_reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    issue(1, 32'hA000, 16'd8, 1, 1, 64'h30, 1, 2'd0);
    wait_done("t6_done", 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #400000;
    flag("watchdog", "got simulation still running, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
